// File: rtl/rf_wport_arb.sv
`default_nettype none
// ============================================================================
// Module   : rf_wport_arb
// Purpose  : Arbiter/sequencer for the single register-file write port.
//            Shares the port between in-order pipeline commit and a queued
//            long-latency unit (LU). LU results wait in a small FIFO and drain
//            into idle write cycles; a starvation counter forces a FIFO grant
//            (stalling commit) once the head has waited STARVE_MAX cycles.
// Ports    : clk, reset (sync, active-low)
//            pipe_valid/pipe_we/pipe_waddr/pipe_wdata -> pipe_stall
//            lu_valid/lu_waddr/lu_wdata               -> lu_ready
//            rf_we/rf_waddr/rf_wdata/rf_src           (write port + source)
//            q_raddr1/q_raddr2 -> pend_hit1/pend_hit2 (queued-write lookup)
// Revision : 1.0 - initial release
// ============================================================================
module rf_wport_arb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_src,
  input  logic [4:0]  q_raddr1,
  input  logic [4:0]  q_raddr2,
  output logic        pend_hit1,
  output logic        pend_hit2
);

  localparam int              c_AW     = $clog2(DEPTH);
  localparam int              c_CW     = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH  = c_CW'(DEPTH);
  localparam logic [3:0]      c_STARVE = 4'(STARVE_MAX);

  logic [4:0]      r_mem_addr [DEPTH];
  logic [31:0]     r_mem_data [DEPTH];
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_CW-1:0] r_count;
  logic [3:0]      r_wait;

  logic             w_pw;
  logic             w_hv;
  logic             w_force;
  logic             w_deq;
  logic             w_acc;
  logic             w_enq;
  logic [DEPTH-1:0] w_ent_valid;
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;

  // Writes to r0 are architectural no-ops: they neither use the port nor stall.
  assign w_pw    = pipe_valid & pipe_we & (pipe_waddr != 5'd0);
  assign w_hv    = (r_count != '0);
  assign w_force = w_hv & (r_wait == c_STARVE);

  // Ready depends only on registered occupancy, so a full FIFO stays closed
  // even in a cycle that drains it (no pass-through).
  assign lu_ready = (r_count < c_DEPTH);
  assign w_acc    = lu_valid & lu_ready;
  assign w_enq    = w_acc & (lu_waddr != 5'd0);

  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_wdata   = 32'd0;
    rf_src     = 1'b0;
    pipe_stall = 1'b0;
    w_deq      = 1'b0;
    if (w_force) begin
      rf_we      = 1'b1;
      rf_waddr   = r_mem_addr[r_rd_ptr];
      rf_wdata   = r_mem_data[r_rd_ptr];
      rf_src     = 1'b1;
      pipe_stall = w_pw;
      w_deq      = 1'b1;
    end else if (w_pw) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_waddr;
      rf_wdata = pipe_wdata;
    end else if (w_hv) begin
      rf_we    = 1'b1;
      rf_waddr = r_mem_addr[r_rd_ptr];
      rf_wdata = r_mem_data[r_rd_ptr];
      rf_src   = 1'b1;
      w_deq    = 1'b1;
    end
  end

  // An entry is live when its distance from the read pointer (mod DEPTH)
  // is below the occupancy count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [c_AW-1:0] w_off;
    assign w_off           = c_AW'(gi) - r_rd_ptr;
    assign w_ent_valid[gi] = ({1'b0, w_off} < r_count);
    assign w_hit1[gi]      = w_ent_valid[gi] & (r_mem_addr[gi] == q_raddr1);
    assign w_hit2[gi]      = w_ent_valid[gi] & (r_mem_addr[gi] == q_raddr2);
  end

  assign pend_hit1 = (q_raddr1 != 5'd0) & (|w_hit1);
  assign pend_hit2 = (q_raddr2 != 5'd0) & (|w_hit2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_wait   <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      if (w_enq && !w_deq)      r_count <= r_count + c_CW'(1);
      else if (w_deq && !w_enq) r_count <= r_count - c_CW'(1);
      // Age of the current head; a fresh head always starts from zero.
      if (w_deq || !w_hv)       r_wait <= 4'd0;
      else if (r_wait != c_STARVE) r_wait <= r_wait + 4'd1;
    end
  end

  // Payload storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (reset && w_enq) begin
      r_mem_addr[r_wr_ptr] <= lu_waddr;
      r_mem_data[r_wr_ptr] <= lu_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wport_arb
// Purpose  : Self-checking bench for rf_wport_arb (directed scenarios plus a
//            randomized run against a queue-based reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wport_arb;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_valid = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_waddr = 5'd0;
  logic [31:0] pipe_wdata = 32'd0;
  logic        pipe_stall;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_waddr = 5'd0;
  logic [31:0] lu_wdata = 32'd0;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_src;
  logic [4:0]  q_raddr1 = 5'd0;
  logic [4:0]  q_raddr2 = 5'd0;
  logic        pend_hit1;
  logic        pend_hit2;

  int checks = 0;
  int errors = 0;

  // {rf_we, rf_waddr, rf_wdata, rf_src, pipe_stall, lu_ready, pend_hit1, pend_hit2}
  logic [42:0] obs;
  assign obs = {rf_we, rf_waddr, rf_wdata, rf_src, pipe_stall, lu_ready, pend_hit1, pend_hit2};

  rf_wport_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_we(pipe_we), .pipe_waddr(pipe_waddr),
    .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src),
    .q_raddr1(q_raddr1), .q_raddr2(q_raddr2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0; pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    lu_valid = 1'b0; lu_waddr = 5'd0; lu_wdata = 32'd0;
    q_raddr1 = 5'd0; q_raddr2 = 5'd0;
  endtask

  task automatic pipe_wr(input logic [4:0] a, input logic [31:0] d);
    pipe_valid = 1'b1; pipe_we = 1'b1; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [42:0] exp_v;
    do_reset();
    q_raddr1 = 5'd5; q_raddr2 = 5'd7;
    pipe_wr(5'd5, 32'h11);
    #1;
    exp_v = {1'b1, 5'd5, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_first_write got %h exp %h", obs, exp_v); end
    tick();
    idle_inputs();
  endtask

  task automatic test_lu_drain();
    logic [42:0] exp_v;
    do_reset();
    q_raddr1 = 5'd7;
    lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'hABCD;
    #1;
    exp_v = {1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL lu_offer got %h exp %h", obs, exp_v); end
    tick();
    lu_valid = 1'b0;
    #1;
    exp_v = {1'b1, 5'd7, 32'hABCD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL lu_drain got %h exp %h", obs, exp_v); end
    tick();
    #1;
    exp_v = {1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL lu_after_drain got %h exp %h", obs, exp_v); end
    tick();
    idle_inputs();
  endtask

  task automatic test_starve();
    logic [42:0] exp_v;
    do_reset();
    q_raddr1 = 5'd9; q_raddr2 = 5'd3;
    pipe_wr(5'd3, 32'h33);
    lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
    #1;
    exp_v = {1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL starve_enq got %h exp %h", obs, exp_v); end
    tick();
    lu_valid = 1'b0;
    for (int k = 0; k < STARVE_MAX; k++) begin
      #1;
      exp_v = {1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL starve_pipe_grant[%0d] got %h exp %h", k, obs, exp_v); end
      tick();
    end
    #1;
    exp_v = {1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL starve_forced got %h exp %h", obs, exp_v); end
    tick();
    #1;
    exp_v = {1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL starve_resume got %h exp %h", obs, exp_v); end
    tick();
    idle_inputs();
  endtask

  task automatic test_full();
    int acc_cyc[$];
    int drain_cyc[$];
    logic [36:0] drained[$];
    logic rdy_hist[20];
    int nsent;
    nsent = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      pipe_wr(5'd4, 32'h44);
      lu_valid = (nsent < 3);
      lu_waddr = 5'(10 + nsent);
      lu_wdata = 32'(32'h100 + nsent);
      #1;
      rdy_hist[c] = lu_ready;
      if (lu_valid && lu_ready) begin acc_cyc.push_back(c); nsent++; end
      if (rf_we && rf_src) begin drained.push_back({rf_waddr, rf_wdata}); drain_cyc.push_back(c); end
      tick();
    end
    idle_inputs();
    checks++;
    if (rdy_hist[2] !== 1'b0 || rdy_hist[5] !== 1'b0 || rdy_hist[6] !== 1'b1)
    begin errors++; $display("FAIL full_ready got c2=%b c5=%b c6=%b exp 0 0 1", rdy_hist[2], rdy_hist[5], rdy_hist[6]); end
    checks++;
    if (acc_cyc.size() != 3 || acc_cyc[0] != 0 || acc_cyc[1] != 1 || acc_cyc[2] != 6)
    begin errors++; $display("FAIL full_accept got %p exp '{0,1,6}", acc_cyc); end
    checks++;
    if (drained.size() != 3 || drained[0] !== {5'd10, 32'h100} || drained[1] !== {5'd11, 32'h101} || drained[2] !== {5'd12, 32'h102})
    begin errors++; $display("FAIL full_order got %p exp 10/100 11/101 12/102", drained); end
    checks++;
    if (drain_cyc.size() == 0 || drain_cyc[0] != 5)
    begin errors++; $display("FAIL full_first_drain got %p exp first 5", drain_cyc); end
  endtask

  task automatic test_r0();
    logic [42:0] exp_v;
    do_reset();
    pipe_wr(5'd0, 32'hFF);
    lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'h55;
    #1;
    exp_v = {1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL r0_offer got %h exp %h", obs, exp_v); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL r0_discarded got %h exp %h", obs, exp_v); end
    tick();
  endtask

  task automatic test_reset_flush();
    logic [42:0] exp_v;
    do_reset();
    pipe_wr(5'd3, 32'h33);
    lu_valid = 1'b1; lu_waddr = 5'd20; lu_wdata = 32'h200;
    tick();
    lu_waddr = 5'd21; lu_wdata = 32'h201;
    tick();
    lu_valid = 1'b0;
    q_raddr1 = 5'd20; q_raddr2 = 5'd21;
    #1;
    exp_v = {1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL flush_queued got %h exp %h", obs, exp_v); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    pipe_valid = 1'b0; pipe_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_v = {1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL flush_after_reset[%0d] got %h exp %h", k, obs, exp_v); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [36:0] mq[$];
    int age;
    logic pw, hv, frc, deq, acc;
    logic e_we, e_src, e_stall, e_rdy, e_h1, e_h2;
    logic [4:0] e_addr;
    logic [31:0] e_data;
    logic [42:0] exp_v;
    do_reset();
    age = 0;
    for (int n = 0; n < 2000; n++) begin
      reset      = ($urandom_range(0, 63) != 0);
      pipe_valid = ($urandom_range(0, 3) != 0);
      pipe_we    = ($urandom_range(0, 3) != 0);
      pipe_waddr = 5'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      lu_valid   = ($urandom_range(0, 2) == 0);
      lu_waddr   = 5'($urandom_range(0, 7));
      lu_wdata   = $urandom;
      q_raddr1   = 5'($urandom_range(0, 7));
      q_raddr2   = 5'($urandom_range(0, 7));
      #1;
      pw  = pipe_valid && pipe_we && (pipe_waddr != 5'd0);
      hv  = (mq.size() > 0);
      frc = hv && (age == STARVE_MAX);
      e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_src = 1'b0; e_stall = 1'b0; deq = 1'b0;
      if (frc) begin
        e_we = 1'b1; {e_addr, e_data} = mq[0]; e_src = 1'b1; e_stall = pw; deq = 1'b1;
      end else if (pw) begin
        e_we = 1'b1; e_addr = pipe_waddr; e_data = pipe_wdata;
      end else if (hv) begin
        e_we = 1'b1; {e_addr, e_data} = mq[0]; e_src = 1'b1; deq = 1'b1;
      end
      e_rdy = (mq.size() < DEPTH);
      e_h1 = 1'b0; e_h2 = 1'b0;
      foreach (mq[k]) begin
        if (q_raddr1 != 5'd0 && mq[k][36:32] == q_raddr1) e_h1 = 1'b1;
        if (q_raddr2 != 5'd0 && mq[k][36:32] == q_raddr2) e_h2 = 1'b1;
      end
      exp_v = {e_we, e_addr, e_data, e_src, e_stall, e_rdy, e_h1, e_h2};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random[%0d] got %h exp %h", n, obs, exp_v); end
      if (!reset) begin
        mq.delete();
        age = 0;
      end else begin
        acc = lu_valid && e_rdy;
        if (deq) begin void'(mq.pop_front()); age = 0; end
        else if (hv) begin if (age < STARVE_MAX) age++; end
        else age = 0;
        if (acc && lu_waddr != 5'd0) mq.push_back({lu_waddr, lu_wdata});
      end
      tick();
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lu_drain();
    test_starve();
    test_full();
    test_r0();
    test_reset_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
